// File: rtl/warp_fetcher.sv
// ---------------------------------------------------------------------------
// warp_fetcher
//
// Per-core instruction fetch unit. While the warp scheduler is in FETCHING it
// reads the selected warp's PC from program memory over a valid/ready
// handshake. It then presents the instruction to the decoder and holds it
// until the scheduler leaves FETCHING. A fetch whose warp/PC no longer
// matches the scheduler's current selection is discarded and refetched.
//
// Optional feature (compile-time macro WARP_FETCHER_IBUF_EN):
//   A one-entry instruction buffer per warp (valid, PC tag, instruction).
//   A tag hit in IDLE skips the memory request and goes straight to FETCHED.
//
// Ports:
//   clk, reset          - clock (rising edge), synchronous active-high reset
//   scheduler_state     - scheduler state: 00 IDLE, 01 FETCHING,
//                         10 PROCESSING, 11 WAITING
//   current_warp_id     - warp the scheduler is fetching for
//   current_pc          - PC of current_warp_id
//   mem_read_valid      - program memory read request
//   mem_read_address    - request address
//   mem_read_ready      - memory acknowledge; data valid in the same cycle
//   mem_read_data       - returned instruction
//   instruction_ready   - instruction is valid for the latched warp and PC
//   instruction         - fetched instruction (registered)
//   fetcher_state       - 00 IDLE, 01 FETCHING, 10 FETCHED
// ---------------------------------------------------------------------------
module warp_fetcher #(
  parameter int MAX_WARPS_PER_CORE    = 2,
  parameter int WARP_ID_BITS          = $clog2(MAX_WARPS_PER_CORE),
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       scheduler_state,
  input  logic [WARP_ID_BITS-1:0]          current_warp_id,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic                             instruction_ready,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [1:0]                       fetcher_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FETCHING = 2'b01,
    ST_FETCHED  = 2'b10
  } state_t;

  localparam logic [1:0] SCHED_FETCHING = 2'b01;

  state_t                             r_state, w_state_nxt;
  logic                               r_mem_valid, w_mem_valid_nxt;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   r_instr, w_instr_nxt;
  logic                               r_instr_ready, w_instr_ready_nxt;
  logic [WARP_ID_BITS-1:0]            r_req_warp, w_req_warp_nxt;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_req_pc, w_req_pc_nxt;

  logic                               w_sched_fetch;
  logic                               w_req_match;
  logic                               w_buf_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   w_buf_instr;

  assign w_sched_fetch = (scheduler_state == SCHED_FETCHING);
  // A mismatch means the scheduler moved on (e.g. skipped a finished warp)
  // and whatever we fetched is stale.
  assign w_req_match   = (current_warp_id == r_req_warp) && (current_pc == r_req_pc);

`ifdef WARP_FETCHER_IBUF_EN
  logic [MAX_WARPS_PER_CORE-1:0]    r_buf_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_buf_tag  [MAX_WARPS_PER_CORE];
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_buf_data [MAX_WARPS_PER_CORE];
  logic                             w_buf_wr;

  assign w_buf_hit   = r_buf_valid[current_warp_id] &&
                       (r_buf_tag[current_warp_id] == current_pc);
  assign w_buf_instr = r_buf_data[current_warp_id];
  // Every completed read fills the entry of the warp that issued it, even
  // when the result turns out to be stale for the scheduler.
  assign w_buf_wr    = (r_state == ST_FETCHING) && mem_read_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= '0;
    end else if (w_buf_wr) begin
      r_buf_valid[r_req_warp] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_wr) begin
      r_buf_tag[r_req_warp]  <= r_req_pc;
      r_buf_data[r_req_warp] <= mem_read_data;
    end
  end
`else
  assign w_buf_hit   = 1'b0;
  assign w_buf_instr = '0;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_mem_valid_nxt   = r_mem_valid;
    w_mem_addr_nxt    = r_mem_addr;
    w_instr_nxt       = r_instr;
    w_instr_ready_nxt = 1'b0;
    w_req_warp_nxt    = r_req_warp;
    w_req_pc_nxt      = r_req_pc;
    case (r_state)
      ST_IDLE: begin
        if (w_sched_fetch) begin
          w_req_warp_nxt = current_warp_id;
          w_req_pc_nxt   = current_pc;
          if (w_buf_hit) begin
            w_instr_nxt       = w_buf_instr;
            w_instr_ready_nxt = 1'b1;
            w_state_nxt       = ST_FETCHED;
          end else begin
            w_mem_valid_nxt = 1'b1;
            w_mem_addr_nxt  = current_pc;
            w_state_nxt     = ST_FETCHING;
          end
        end
      end
      ST_FETCHING: begin
        // The request stays up until acknowledged; only reset withdraws it.
        if (mem_read_ready) begin
          w_instr_nxt       = mem_read_data;
          w_mem_valid_nxt   = 1'b0;
          w_state_nxt       = ST_FETCHED;
          w_instr_ready_nxt = w_sched_fetch && w_req_match;
        end
      end
      ST_FETCHED: begin
        if (!w_sched_fetch || !w_req_match) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_instr_ready_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_mem_valid   <= 1'b0;
      r_mem_addr    <= '0;
      r_instr       <= '0;
      r_instr_ready <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mem_valid   <= w_mem_valid_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_ready <= w_instr_ready_nxt;
    end
  end

  // The request tag is only meaningful once a fetch has been launched.
  always_ff @(posedge clk) begin
    r_req_warp <= w_req_warp_nxt;
    r_req_pc   <= w_req_pc_nxt;
  end

  assign mem_read_valid    = r_mem_valid;
  assign mem_read_address  = r_mem_addr;
  assign instruction       = r_instr;
  assign instruction_ready = r_instr_ready;
  assign fetcher_state     = r_state;

endmodule

// File: tb/tb_warp_fetcher.sv
// ---------------------------------------------------------------------------
// tb_warp_fetcher
//
// Self-checking bench for warp_fetcher. The bench plays both the scheduler
// and the program memory. A flat memory image and a per-warp buffer model
// (used only when WARP_FETCHER_IBUF_EN is defined) give the expected
// instruction, address and latency of every fetch.
// ---------------------------------------------------------------------------
module tb_warp_fetcher;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int WB = 1;
`ifdef WARP_FETCHER_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    scheduler_state;
  logic [WB-1:0] current_warp_id;
  logic [AW-1:0] current_pc;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic          instruction_ready;
  logic [DW-1:0] instruction;
  logic [1:0]    fetcher_state;

  always #5 clk = ~clk;

  warp_fetcher #(
    .MAX_WARPS_PER_CORE   (2),
    .WARP_ID_BITS         (WB),
    .PROGRAM_MEM_ADDR_BITS(AW),
    .PROGRAM_MEM_DATA_BITS(DW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .scheduler_state  (scheduler_state),
    .current_warp_id  (current_warp_id),
    .current_pc       (current_pc),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .instruction_ready(instruction_ready),
    .instruction      (instruction),
    .fetcher_state    (fetcher_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [256];
  bit            mdl_buf_vld [2];
  logic [AW-1:0] mdl_buf_pc  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_clear;
    for (int i = 0; i < 2; i++) mdl_buf_vld[i] = 1'b0;
  endtask

  task automatic do_reset;
    reset           = 1'b1;
    scheduler_state = 2'b00;
    mem_read_ready  = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    mdl_clear;
  endtask

  // One complete scheduler fetch phase: enter FETCHING, serve the memory
  // after 'lat' wait cycles, hold for 'hold' cycles, then move to PROCESSING.
  task automatic do_fetch(input logic [WB-1:0] w, input logic [AW-1:0] pc,
                          input int lat, input int hold);
    bit hit;
    hit = IBUF && mdl_buf_vld[w] && (mdl_buf_pc[w] == pc);
    scheduler_state = 2'b01;
    current_warp_id = w;
    current_pc      = pc;
    tick;
    if (hit) begin
      check_eq("hit_no_valid", mem_read_valid, 1'b0);
      check_eq("hit_ready", instruction_ready, 1'b1);
      check_eq("hit_instr", instruction, mem[pc]);
      check_eq("hit_state", fetcher_state, 2'b10);
    end else begin
      check_eq("req_valid", mem_read_valid, 1'b1);
      check_eq("req_addr", mem_read_address, pc);
      check_eq("req_state", fetcher_state, 2'b01);
      check_eq("req_not_ready", instruction_ready, 1'b0);
      for (int k = 0; k < lat; k++) begin
        mem_read_ready = 1'b0;
        mem_read_data  = DW'($urandom);
        tick;
        check_eq("wait_valid", mem_read_valid, 1'b1);
        check_eq("wait_addr", mem_read_address, pc);
        check_eq("wait_not_ready", instruction_ready, 1'b0);
      end
      mem_read_ready = 1'b1;
      mem_read_data  = mem[pc];
      tick;
      mem_read_ready = 1'b0;
      mem_read_data  = DW'($urandom);
      check_eq("done_valid_low", mem_read_valid, 1'b0);
      check_eq("done_ready", instruction_ready, 1'b1);
      check_eq("done_instr", instruction, mem[pc]);
      check_eq("done_state", fetcher_state, 2'b10);
      mdl_buf_vld[w] = 1'b1;
      mdl_buf_pc[w]  = pc;
    end
    for (int h = 0; h < hold; h++) begin
      tick;
      check_eq("hold_ready", instruction_ready, 1'b1);
      check_eq("hold_instr", instruction, mem[pc]);
      check_eq("hold_valid_low", mem_read_valid, 1'b0);
    end
    scheduler_state = 2'b10;
    tick;
    check_eq("leave_ready", instruction_ready, 1'b0);
    check_eq("leave_state", fetcher_state, 2'b00);
    check_eq("leave_instr_kept", instruction, mem[pc]);
  endtask

  initial begin
    logic [WB-1:0] rw;
    logic [AW-1:0] rpc;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h05] = 16'h3A7C;
    mdl_clear;
    current_warp_id = '0;
    current_pc      = '0;
    mem_read_data   = '0;

    // Reset state
    do_reset;
    check_eq("rst_state", fetcher_state, 2'b00);
    check_eq("rst_valid", mem_read_valid, 1'b0);
    check_eq("rst_addr", mem_read_address, 8'h00);
    check_eq("rst_instr", instruction, 16'h0000);
    check_eq("rst_ready", instruction_ready, 1'b0);

    // Basic fetch, then a 4-cycle memory wait
    do_fetch(1'b0, 8'h05, 0, 2);
    do_reset;
    do_fetch(1'b0, 8'h05, 4, 1);

    // Stale warp: scheduler switches 0/0x05 -> 1/0x09 mid-request
    do_reset;
    scheduler_state = 2'b01; current_warp_id = 1'b0; current_pc = 8'h05;
    tick;
    check_eq("st_valid", mem_read_valid, 1'b1);
    check_eq("st_addr", mem_read_address, 8'h05);
    current_warp_id = 1'b1; current_pc = 8'h09;
    tick;
    check_eq("st_hold_valid", mem_read_valid, 1'b1);
    check_eq("st_hold_addr", mem_read_address, 8'h05);
    mem_read_ready = 1'b1; mem_read_data = mem[8'h05];
    tick;
    mem_read_ready = 1'b0;
    check_eq("st_no_ready", instruction_ready, 1'b0);
    check_eq("st_fetched", fetcher_state, 2'b10);
    check_eq("st_instr", instruction, mem[8'h05]);
    mdl_buf_vld[0] = 1'b1; mdl_buf_pc[0] = 8'h05;
    tick;
    check_eq("st_idle", fetcher_state, 2'b00);
    check_eq("st_idle_ready", instruction_ready, 1'b0);
    tick;
    check_eq("st_refetch_valid", mem_read_valid, 1'b1);
    check_eq("st_refetch_addr", mem_read_address, 8'h09);
    mem_read_ready = 1'b1; mem_read_data = mem[8'h09];
    tick;
    mem_read_ready = 1'b0;
    check_eq("st_re_ready", instruction_ready, 1'b1);
    check_eq("st_re_instr", instruction, mem[8'h09]);
    mdl_buf_vld[1] = 1'b1; mdl_buf_pc[1] = 8'h09;
    scheduler_state = 2'b10;
    tick;
    check_eq("st_leave_ready", instruction_ready, 1'b0);

    // Scheduler leaves FETCHING while the read is outstanding
    do_reset;
    scheduler_state = 2'b01; current_warp_id = 1'b0; current_pc = 8'h20;
    tick;
    check_eq("lv_valid", mem_read_valid, 1'b1);
    scheduler_state = 2'b10;
    tick;
    check_eq("lv_not_withdrawn", mem_read_valid, 1'b1);
    check_eq("lv_addr", mem_read_address, 8'h20);
    mem_read_ready = 1'b1; mem_read_data = mem[8'h20];
    tick;
    mem_read_ready = 1'b0;
    check_eq("lv_fetched", fetcher_state, 2'b10);
    check_eq("lv_no_ready", instruction_ready, 1'b0);
    check_eq("lv_instr", instruction, mem[8'h20]);
    tick;
    check_eq("lv_idle", fetcher_state, 2'b00);
    check_eq("lv_idle_ready", instruction_ready, 1'b0);

    // Reset mid-request
    do_reset;
    scheduler_state = 2'b01; current_warp_id = 1'b1; current_pc = 8'h33;
    tick;
    check_eq("rm_valid", mem_read_valid, 1'b1);
    reset = 1'b1;
    tick;
    check_eq("rm_valid_low", mem_read_valid, 1'b0);
    check_eq("rm_ready_low", instruction_ready, 1'b0);
    check_eq("rm_state", fetcher_state, 2'b00);
    reset = 1'b0;
    scheduler_state = 2'b00;
    mdl_clear;
    tick;

    // Buffer hit and isolation (all misses without the buffer)
    do_fetch(1'b1, 8'h10, 1, 1);
    do_fetch(1'b1, 8'h10, 2, 1);
    do_reset;
    do_fetch(1'b0, 8'h10, 0, 0);
    do_fetch(1'b1, 8'h10, 1, 0);

    // Top-of-range address
    do_fetch(1'b0, 8'hFF, 1, 1);

    // Randomized fetch phases with occasional idle gaps
    for (int it = 0; it < 60; it++) begin
      rw = WB'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: rpc = 8'h05;
        1: rpc = 8'h10;
        2: rpc = 8'hFF;
        3: rpc = 8'h00;
        default: rpc = AW'($urandom);
      endcase
      do_fetch(rw, rpc, $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) begin
        scheduler_state = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        tick;
        check_eq("gap_idle", fetcher_state, 2'b00);
        check_eq("gap_no_valid", mem_read_valid, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/warp_fetcher.md
# warp_fetcher

Per-core instruction fetch unit that responds to the warp scheduler's fetch phase. While the scheduler sits in FETCHING, it reads the selected warp's PC from program memory over a valid/ready handshake. It then presents the instruction to the decoder with `instruction_ready` and holds it until the scheduler leaves FETCHING. It sits between the warp scheduler and the core's port on the program memory controller.

## Interface
Parameters:
- `MAX_WARPS_PER_CORE`, default 2: number of warp contexts.
- `WARP_ID_BITS`, default `$clog2(MAX_WARPS_PER_CORE)`: width of warp id.
- `PROGRAM_MEM_ADDR_BITS`, default 8: PC and address width.
- `PROGRAM_MEM_DATA_BITS`, default 16: instruction width.

Ports:
- `clk`, input, 1: clock; all logic on the rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `scheduler_state`, input, 2: scheduler state; IDLE=00, FETCHING=01, PROCESSING=10, WAITING=11.
- `current_warp_id`, input, `WARP_ID_BITS`: warp the scheduler is fetching for.
- `current_pc`, input, `PROGRAM_MEM_ADDR_BITS`: PC of `current_warp_id`.
- `mem_read_valid`, output, 1: program memory read request.
- `mem_read_address`, output, `PROGRAM_MEM_ADDR_BITS`: request address.
- `mem_read_ready`, input, 1: memory acknowledge; `mem_read_data` is valid in the same cycle.
- `mem_read_data`, input, `PROGRAM_MEM_DATA_BITS`: returned instruction.
- `instruction_ready`, output, 1: `instruction` is valid for the latched warp and PC.
- `instruction`, output, `PROGRAM_MEM_DATA_BITS`: fetched instruction, registered.
- `fetcher_state`, output, 2: IDLE=00, FETCHING=01, FETCHED=10.

## Operation
- Internal registers: `req_warp`, which latches `current_warp_id`, and `req_pc`, which latches `current_pc`.
- **IDLE.** When `scheduler_state==01`:
  - latch `req_warp` and `req_pc`;
  - set `mem_read_valid=1` and `mem_read_address=current_pc`;
  - go to FETCHING.
- **FETCHING.**
  - `mem_read_valid` and `mem_read_address` stay stable until `mem_read_ready` is sampled high.
  - On that edge: `instruction <= mem_read_data`, `mem_read_valid <= 0`, go to FETCHED.
  - The request is never withdrawn once issued, except by reset.
- **FETCHED.** Evaluate in this priority order:
  1. If `scheduler_state!=01`: go to IDLE and clear `instruction_ready`. `instruction` keeps its value.
  2. Else if `current_warp_id!=req_warp` or `current_pc!=req_pc` (stale: the scheduler skipped a done warp): go to IDLE with `instruction_ready=0`, so the next cycle refetches.
  3. Else: stay, with `instruction_ready=1`.
- `instruction_ready` is a registered output.
  - It is 1 only in FETCHED, and only when `req_warp` and `req_pc` match the current inputs.
  - It is never 1 for a stale fetch.
- Entering FETCHING while the scheduler's warp changes mid-request is allowed: the outstanding read completes, then FETCHED rule 2 discards it.
- Scheduler leaving FETCHING while the fetcher is in FETCHING: the read completes, FETCHED is entered, and rule 1 returns the fetcher to IDLE. `instruction_ready` is never raised.

## Timing
- Reset values: `fetcher_state=00`, `mem_read_valid=0`, `mem_read_address=0`, `instruction=0`, `instruction_ready=0`.
- Reset mid-request drops `mem_read_valid` on the same edge.
- Memory miss latency, with the scheduler entering FETCHING at edge E0:
  - `mem_read_valid` is high after E1.
  - If `mem_read_ready` is high in the cycle before E2, `instruction_ready` is high after E2.
  - Each memory wait cycle adds one cycle.
- One request is outstanding at most. Back-to-back fetches need one IDLE cycle between requests.
- `mem_read_address` is 8-bit; no wrap logic is needed. PC 0xFF is a legal address.

## Configuration
- Macro: `WARP_FETCHER_IBUF_EN`.
- **Defined:**
  - Adds a per-warp one-entry instruction buffer: valid bit, PC tag and instruction.
  - In IDLE, if `scheduler_state==01` and the entry for `current_warp_id` is valid with a tag equal to `current_pc`: load `instruction` from the buffer, go directly to FETCHED, and issue no memory request. `instruction_ready` is high after E1.
  - Every completed memory read writes the entry for `req_warp`.
  - Reset clears all valid bits.
- **Undefined:** no buffer; every fetch goes to memory.

## Test plan
- **Basic fetch.** Reset, then `scheduler_state=01`, warp 0, PC 0x05; memory returns 0x3A7C one cycle after valid. Required: address 0x05, one-cycle valid pulse, `instruction=0x3A7C`, `instruction_ready=1` until `scheduler_state=10`, then 0.
- **Memory wait.** Memory holds `mem_read_ready=0` for 4 cycles. Required: valid and address stable for 5 cycles, `instruction_ready` delayed by exactly 4 cycles.
- **Stale warp.** `current_warp_id` changes 0→1, with PC 0x05→0x09, while in FETCHING. Required: the 0x05 read completes, `instruction_ready` stays 0, and a second request to 0x09 follows.
- **Reset mid-request.** Assert reset while valid is high. Required: valid and `instruction_ready` are 0 on the next edge; `fetcher_state=00`.
- **Buffer hit (`WARP_FETCHER_IBUF_EN`).** Fetch warp 1, PC 0x10, return to PROCESSING, then fetch warp 1 PC 0x10 again. Required: no second `mem_read_valid`, and `instruction_ready` is high one cycle after FETCHING.
- **Buffer isolation (`WARP_FETCHER_IBUF_EN`).** Fetch warp 0 PC 0x10, then warp 1 PC 0x10. Required: warp 1 misses and issues a memory read.
